// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared constants and helpers for the clk_div_bank divider bank.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int NUM_CH_DEF    = 2;
    localparam int CTR_WIDTH_DEF = 9;

    // A single channel still needs a 1-bit select so the port never vanishes.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_IDX_W_DEF = ch_idx_w(NUM_CH_DEF);

    function automatic int div_period(input int d);
        return 2 * (d + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_if
// Description : Control/status bundle of the divider bank. CE_FALL exists only
//               when CLKDIV_CE_FALL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_if
    import clk_div_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int CTR_WIDTH = CTR_WIDTH_DEF
);
    logic [NUM_CH-1:0]           ch_en;
    logic                        sync;
    logic                        wr_en;
    logic [ch_idx_w(NUM_CH)-1:0] wr_ch;
    logic [CTR_WIDTH-1:0]        wr_div;
    logic [NUM_CH-1:0]           clk_out;
    logic [NUM_CH-1:0]           ce;
    logic [NUM_CH-1:0]           pend;
`ifdef CLKDIV_CE_FALL_EN
    logic [NUM_CH-1:0]           ce_fall;
`endif

    modport master (
        output ch_en, sync, wr_en, wr_ch, wr_div,
        input  clk_out, ce, pend
`ifdef CLKDIV_CE_FALL_EN
        , input ce_fall
`endif
    );

    modport slave (
        input  ch_en, sync, wr_en, wr_ch, wr_div,
        output clk_out, ce, pend
`ifdef CLKDIV_CE_FALL_EN
        , output ce_fall
`endif
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ch
// Description : One divider channel with glitch-free divisor reload at the
//               falling edge. CE_FALL strobe present under CLKDIV_CE_FALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ch #(
    parameter int                   CTR_WIDTH = 9,
    parameter logic [CTR_WIDTH-1:0] DIV_RESET = '0
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    input  wire logic                 en_i,
    input  wire logic                 sync_i,
    input  wire logic                 wr_i,
    input  wire logic [CTR_WIDTH-1:0] wr_div_i,
    output logic                      clk_o,
    output logic                      ce_o,
    output logic                      pend_o
`ifdef CLKDIV_CE_FALL_EN
    , output logic                    ce_fall_o
`endif
);

    logic [CTR_WIDTH-1:0] ctr_q,  ctr_d;
    logic [CTR_WIDTH-1:0] div_q,  div_d;
    logic [CTR_WIDTH-1:0] pdiv_q, pdiv_d;
    logic                 pend_q, pend_d;
    logic                 clk_q,  clk_d;
    logic                 ce_q,   ce_d;
`ifdef CLKDIV_CE_FALL_EN
    logic                 cef_q,  cef_d;
`endif

    always_comb begin
        ctr_d  = ctr_q;
        div_d  = div_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        ce_d   = 1'b0;
`ifdef CLKDIV_CE_FALL_EN
        cef_d  = 1'b0;
`endif
        if (sync_i || !en_i) begin
            ctr_d = '0;
            clk_d = 1'b0;
            if (pend_q) begin
                div_d  = pdiv_q;
                pend_d = 1'b0;
            end
        end else if (ctr_q == div_q) begin
            ctr_d = '0;
            clk_d = ~clk_q;
            ce_d  = ~clk_q;
`ifdef CLKDIV_CE_FALL_EN
            cef_d = clk_q;
`endif
            // Reload only while leaving the high half, so a period is never cut.
            if (clk_q && pend_q) begin
                div_d  = pdiv_q;
                pend_d = 1'b0;
            end
        end else begin
            ctr_d = ctr_q + CTR_WIDTH'(1);
        end
        // A coincident write is kept pending; any apply above used the old value.
        if (wr_i) begin
            pdiv_d = wr_div_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctr_q  <= '0;
            div_q  <= DIV_RESET;
            pdiv_q <= '0;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            ce_q   <= 1'b0;
`ifdef CLKDIV_CE_FALL_EN
            cef_q  <= 1'b0;
`endif
        end else begin
            ctr_q  <= ctr_d;
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            ce_q   <= ce_d;
`ifdef CLKDIV_CE_FALL_EN
            cef_q  <= cef_d;
`endif
        end
    end

    assign clk_o  = clk_q;
    assign ce_o   = ce_q;
    assign pend_o = pend_q;
`ifdef CLKDIV_CE_FALL_EN
    assign ce_fall_o = cef_q;
`endif

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank
// Description : NUM_CH runtime-programmable clock dividers with write decode.
//               Optional CE_FALL output enabled by CLKDIV_CE_FALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int                            NUM_CH        = NUM_CH_DEF,
    parameter int                            CTR_WIDTH     = CTR_WIDTH_DEF,
    parameter logic [NUM_CH*CTR_WIDTH-1:0]   DIV_RESET_VEC = {9'd12, 9'd0}
) (
    input wire logic  clk_i,
    input wire logic  rst_i,
    clk_div_if.slave  bus
);

    localparam int IDX_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] w_clk;
    logic [NUM_CH-1:0] w_ce;
    logic [NUM_CH-1:0] w_pend;
`ifdef CLKDIV_CE_FALL_EN
    logic [NUM_CH-1:0] w_cef;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no index and are dropped here.
        logic w_wr;
        assign w_wr = bus.wr_en && (bus.wr_ch == IDX_W'(i));

        clk_div_ch #(
            .CTR_WIDTH (CTR_WIDTH),
            .DIV_RESET (DIV_RESET_VEC[i*CTR_WIDTH +: CTR_WIDTH])
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (bus.ch_en[i]),
            .sync_i    (bus.sync),
            .wr_i      (w_wr),
            .wr_div_i  (bus.wr_div),
            .clk_o     (w_clk[i]),
            .ce_o      (w_ce[i]),
            .pend_o    (w_pend[i])
`ifdef CLKDIV_CE_FALL_EN
            , .ce_fall_o (w_cef[i])
`endif
        );
    end

    assign bus.clk_out = w_clk;
    assign bus.ce      = w_ce;
    assign bus.pend    = w_pend;
`ifdef CLKDIV_CE_FALL_EN
    assign bus.ce_fall = w_cef;
`endif

endmodule
`default_nettype wire
